picoram_bus_arbiter: RTL and testbench

Two-master arbiter for the PicoRV32 native memory bus inside `picoram`. It shares the single on-chip RAM/peripheral slave port between the CPU (master 0) and a second bus master (master 1, DMA or debug loader). Arbitration is round-robin, and each transaction is held atomically from grant to `ready`. A watchdog aborts any transaction the slave does not complete within a bounded number of cycles, so a missing peripheral cannot hang the SoC.

---
 rtl/picoram_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_picoram_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/picoram_bus_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native-bus slave between two masters.
// A transaction is held from grant to s_ready; a watchdog aborts transactions that stall.
module picoram_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_irq
);

  // Handshake: a master holds valid until its ready pulse; s_valid stays high
  // from grant until the cycle s_ready is seen, with request fields frozen.

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  grant_q, grant_nxt;
  logic        last, last_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        instr_q, instr_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [3:0]  wstrb_q, wstrb_nxt;
  logic        pick1;
  logic        done;
  logic [31:0] rdata_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      last    <= 1'b1;
      cnt     <= 16'd0;
      instr_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      instr_q <= instr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      wstrb_q <= wstrb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last;
    cnt_nxt   = cnt;
    instr_nxt = instr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    wstrb_nxt = wstrb_q;
    // m1 wins when alone, or on a tie when m0 was the previous owner
    pick1     = m1_valid && (!m0_valid || !last);
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt = BUSY;
          grant_nxt = pick1 ? 2'b10 : 2'b01;
          last_nxt  = pick1;
          cnt_nxt   = 16'd0;
          instr_nxt = pick1 ? m1_instr : m0_instr;
          addr_nxt  = pick1 ? m1_addr  : m0_addr;
          wdata_nxt = pick1 ? m1_wdata : m0_wdata;
          wstrb_nxt = pick1 ? m1_wstrb : m0_wstrb;
        end
      end
      BUSY: begin
        if (cnt != 16'hFFFF) cnt_nxt = cnt + 16'd1;
        if (s_ready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  assign done        = ((state == BUSY) && s_ready) || (state == ABORT);
  assign rdata_src   = (state == ABORT) ? TIMEOUT_DATA : s_rdata;
  assign m0_ready    = done && grant_q[0];
  assign m1_ready    = done && grant_q[1];
  assign m0_rdata    = m0_ready ? rdata_src : 32'd0;
  assign m1_rdata    = m1_ready ? rdata_src : 32'd0;
  assign s_valid     = (state == BUSY);
  assign s_instr     = instr_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_wstrb     = wstrb_q;
  assign grant       = grant_q;
  assign timeout_irq = (state == ABORT);

endmodule

// File: tb/tb_picoram_bus_arbiter.sv
// Directed bench for picoram_bus_arbiter with TIMEOUT=8; inputs change 1ns after
// each rising edge and outputs are checked 1ns later.
module tb_picoram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  picoram_bus_arbiter #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_irq(timeout_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_svalid"}, 32'(s_valid), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_m0rdy"}, 32'(m0_ready), 32'd0);
    chk({tag, "_m1rdy"}, 32'(m1_ready), 32'd0);
    chk({tag, "_irq"}, 32'(timeout_irq), 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    reset = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst_saddr", s_addr, 32'd0);
    chk("rst_m0rdata", m0_rdata, 32'd0);

    // single m0 read, slave ready one cycle after s_valid
    m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0; m0_instr = 1;
    #1 chk("t1_svalid_n", 32'(s_valid), 32'd0);
    cyc();
    chk("t1_svalid", 32'(s_valid), 32'd1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_saddr", s_addr, 32'h0000_0100);
    chk("t1_sinstr", 32'(s_instr), 32'd1);
    chk("t1_m0rdy_wait", 32'(m0_ready), 32'd0);
    cyc();
    s_ready = 1; s_rdata = 32'h1234_5678;
    #1;
    chk("t1_m0rdy", 32'(m0_ready), 32'd1);
    chk("t1_m0rdata", m0_rdata, 32'h1234_5678);
    chk("t1_m1rdy", 32'(m1_ready), 32'd0);
    chk("t1_m1rdata", m1_rdata, 32'd0);
    m0_valid = 0; m0_instr = 0;
    cyc();
    s_ready = 0;
    #1;
    chk_idle("t1_end");
    chk("t1_m0rdata_end", m0_rdata, 32'd0);

    // tie from reset, 0-wait slave: m0, m1, m0, m1 with a bubble between
    reset = 1;
    cyc();
    reset = 0;
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20;
    s_ready = 1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    #1 chk("t2_idle_grant", 32'(grant), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_rdata = 32'hA000_0000 + 32'(i);
      #1;
      e = exp_q.pop_front();
      chk("t2_svalid", 32'(s_valid), 32'd1);
      chk("t2_grant", 32'(grant), e);
      chk("t2_saddr", s_addr, e[0] ? 32'h10 : 32'h20);
      chk("t2_m0rdy", 32'(m0_ready), 32'(e[0]));
      chk("t2_m1rdy", 32'(m1_ready), 32'(e[1]));
      chk("t2_rdata", e[0] ? m0_rdata : m1_rdata, 32'hA000_0000 + 32'(i));
      cyc();
      chk_idle("t2_bubble");
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;

    // m1 write; master fields change while BUSY
    m1_valid = 1; m1_addr = 32'h0200_0004; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    cyc();
    m1_addr = 32'hFFFF_0000; m1_wdata = 32'h1111_1111; m1_wstrb = 4'hF; m1_instr = 1;
    #1;
    chk("t3_grant", 32'(grant), 32'h2);
    for (int k = 0; k < 2; k++) begin
      chk("t3_saddr", s_addr, 32'h0200_0004);
      chk("t3_swdata", s_wdata, 32'hAABB_CCDD);
      chk("t3_swstrb", 32'(s_wstrb), 32'h3);
      chk("t3_sinstr", 32'(s_instr), 32'd0);
      cyc();
    end
    s_ready = 1; s_rdata = 32'h0;
    #1;
    chk("t3_m1rdy", 32'(m1_ready), 32'd1);
    chk("t3_m0rdy", 32'(m0_ready), 32'd0);
    chk("t3_saddr_done", s_addr, 32'h0200_0004);
    m1_valid = 0; m1_instr = 0;
    cyc();
    s_ready = 0;
    #1 chk_idle("t3_end");

    // watchdog abort on an m0 read
    m0_valid = 1; m0_addr = 32'h300;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t4_svalid", 32'(s_valid), 32'd1);
      chk("t4_m0rdy_wait", 32'(m0_ready), 32'd0);
      chk("t4_irq_wait", 32'(timeout_irq), 32'd0);
    end
    cyc();
    chk("t4_svalid_abort", 32'(s_valid), 32'd0);
    chk("t4_m0rdy", 32'(m0_ready), 32'd1);
    chk("t4_m0rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t4_irq", 32'(timeout_irq), 32'd1);
    chk("t4_grant", 32'(grant), 32'h1);
    chk("t4_m1rdy", 32'(m1_ready), 32'd0);
    m0_valid = 0;
    cyc();
    chk_idle("t4_after");
    m1_valid = 1; m1_addr = 32'h400;
    cyc();
    chk("t4_next_svalid", 32'(s_valid), 32'd1);
    chk("t4_next_grant", 32'(grant), 32'h2);
    s_ready = 1; s_rdata = 32'h0000_0055;
    #1;
    chk("t4_next_m1rdata", m1_rdata, 32'h0000_0055);
    m1_valid = 0;
    cyc();
    s_ready = 0;

    // completion on the last BUSY cycle beats the watchdog
    m0_valid = 1; m0_addr = 32'h500;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t5_svalid", 32'(s_valid), 32'd1);
    end
    cyc();
    s_ready = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    chk("t5_m0rdy", 32'(m0_ready), 32'd1);
    chk("t5_m0rdata", m0_rdata, 32'hCAFE_F00D);
    chk("t5_irq", 32'(timeout_irq), 32'd0);
    m0_valid = 0;
    cyc();
    s_ready = 0;
    #1 chk_idle("t5_end");

    // reset while m1 owns the bus
    m1_valid = 1; m1_addr = 32'h600;
    cyc();
    chk("t6_grant", 32'(grant), 32'h2);
    cyc();
    reset = 1;
    #1 chk("t6_m1rdy_rst", 32'(m1_ready), 32'd0);
    cyc();
    reset = 0;
    m0_valid = 1; m0_addr = 32'h700;
    #1;
    chk_idle("t6_after_rst");
    chk("t6_saddr", s_addr, 32'd0);
    cyc();
    chk("t6_tie_grant", 32'(grant), 32'h1);
    chk("t6_tie_saddr", s_addr, 32'h700);
    s_ready = 1; s_rdata = 32'h77;
    #1 chk("t6_m0rdata", m0_rdata, 32'h77);
    m0_valid = 0;
    cyc();
    cyc();
    chk("t6_m1_grant", 32'(grant), 32'h2);
    chk("t6_m1rdy", 32'(m1_ready), 32'd1);
    m1_valid = 0;
    cyc();
    s_ready = 0;
    #1 chk_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
